// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and constants for the hazard/forwarding controller.
// Forward select codes, register-zero index and the shadow slot record.
package cpu_pipe_pkg;

    localparam int unsigned RegW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [RegW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic            valid;
        logic [RegW-1:0] dest;
        logic            we;
        logic            is_load;
    } hz_slot_t;

    // Youngest producer wins: EX slot over MEM slot.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request and hazard/forwarding control bundle.
// id_byp_a/id_byp_b exist only when HZ_RF_BYPASS_EN is defined.
interface hazard_fwd_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) ();

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_reg_we;
    logic             id_is_load;
    logic             ex_flush;

    logic             pc_wr_en;
    logic             ifid_wr_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       ex_fwd_a_sel;
    logic [1:0]       ex_fwd_b_sel;
`ifdef HZ_RF_BYPASS_EN
    logic             id_byp_a;
    logic             id_byp_b;
`endif
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_we, id_is_load,
        output ex_flush,
        input  pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, ex_fwd_a_sel, ex_fwd_b_sel,
`ifdef HZ_RF_BYPASS_EN
        input  id_byp_a, id_byp_b,
`endif
        input  stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_we, id_is_load,
        input  ex_flush,
        output pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, ex_fwd_a_sel, ex_fwd_b_sel,
`ifdef HZ_RF_BYPASS_EN
        output id_byp_a, id_byp_b,
`endif
        output stall_cnt
    );

endinterface

// File: rtl/hz_slot_match.sv
// Hit detection of one shadow pipeline slot against one ID source register.
module hz_slot_match
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned REG_W = RegW
) (
    input  logic             valid_i,
    input  logic             we_i,
    input  logic [REG_W-1:0] dest_i,
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    output logic             hit_o
);

    assign hit_o = valid_i & we_i & use_i & (dest_i == src_i) & (src_i != REG_ZERO);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadow EX/MEM/WB slots,
// load-use stall, EX operand forward selects. HZ_RF_BYPASS_EN enables the ID RF bypass.
module hazard_fwd_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned REG_W = RegW,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_slot_t         ex_q, mem_q, wb_q, ex_d;
    hz_slot_t [2:0]   slots;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       hit_a, hit_b;
    logic             use_rs, use_rt;
    logic             load_use, wb_stall, stall, kill;
    logic             unused_load_bits;

    assign slots  = {wb_q, mem_q, ex_q};
    assign use_rs = hz.id_valid & hz.id_use_rs;
    assign use_rt = hz.id_valid & hz.id_use_rt;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    for (genvar g = 0; g < 3; g++) begin : g_slot
        hz_slot_match #(.REG_W(REG_W)) u_match_a (
            .valid_i (slots[g].valid),
            .we_i    (slots[g].we),
            .dest_i  (slots[g].dest),
            .src_i   (hz.id_rs),
            .use_i   (use_rs),
            .hit_o   (hit_a[g])
        );
        hz_slot_match #(.REG_W(REG_W)) u_match_b (
            .valid_i (slots[g].valid),
            .we_i    (slots[g].we),
            .dest_i  (slots[g].dest),
            .src_i   (hz.id_rt),
            .use_i   (use_rt),
            .hit_o   (hit_b[g])
        );
    end

    assign unused_load_bits = mem_q.is_load ^ wb_q.is_load;

    always_comb begin
        load_use = (hit_a[0] | hit_b[0]) & ex_q.is_load;
`ifdef HZ_RF_BYPASS_EN
        wb_stall = 1'b0;
`else
        // Without the RF bypass, wait one cycle for the WB write to land.
        wb_stall = (hit_a[2] & ~hit_a[1] & ~hit_a[0]) | (hit_b[2] & ~hit_b[1] & ~hit_b[0]);
`endif
        stall = (load_use | wb_stall) & ~hz.ex_flush;
        kill  = stall | hz.ex_flush;
    end

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        cnt_d   = cnt_q;
        if (!kill) begin
            fwd_a_d = fwd_sel(hit_a[0], hit_a[1]);
            fwd_b_d = fwd_sel(hit_b[0], hit_b[1]);
            if (hz.id_valid) begin
                ex_d = '{valid: 1'b1, dest: hz.id_dest, we: hz.id_reg_we,
                         is_load: hz.id_is_load};
            end
        end
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_wr_en     = ~stall;
    assign hz.ifid_wr_en   = ~stall;
    assign hz.ifid_flush   = hz.ex_flush;
    assign hz.idex_bubble  = kill;
    assign hz.ex_fwd_a_sel = fwd_a_q;
    assign hz.ex_fwd_b_sel = fwd_b_q;
    assign hz.stall_cnt    = cnt_q;
`ifdef HZ_RF_BYPASS_EN
    assign hz.id_byp_a     = hit_a[2];
    assign hz.id_byp_b     = hit_b[2];
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the static 5-stage MIPS pipeline. It keeps its own shadow copy of the destination register, write-enable and load flag for the EX, MEM and WB slots. Each cycle it compares the ID-stage instruction's sources against that shadow, then produces the select codes that steer the EX-stage operand 4-1 muxes, plus the stall, bubble and flush strobes for the PC and the pipeline registers. It is the driver of the datapath mux select lines.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `CNT_W`, 16: stall performance-counter width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID slot holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W  ID source register indices.
- `id_use_rs`, `id_use_rt`  in  1  the instruction actually reads that source.
- `id_dest`  in  REG_W  ID destination index (already muxed rt/rd/31).
- `id_reg_we`  in  1  ID instruction writes the register file.
- `id_is_load`  in  1  ID instruction is lw/lb/lh etc.
- `ex_flush`  in  1  branch or jump taken, resolved in EX.
- `pc_wr_en`  out  1  PC update enable.
- `ifid_wr_en`  out  1  IF/ID register write enable.
- `ifid_flush`  out  1  clear IF/ID to a nop.
- `idex_bubble`  out  1  load a nop into ID/EX.
- `ex_fwd_a_sel`, `ex_fwd_b_sel`  out  2  EX operand mux selects, registered.
- `id_byp_a`, `id_byp_b`  out  1  ID register-file bypass selects. Present only with `HZ_RF_BYPASS_EN`.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- Shadow slots EX, MEM and WB each hold {valid, dest, we, is_load}.
- On every edge the slots shift: WB←MEM, MEM←EX, EX←ID.
- EX←ID loads an invalid entry (bubble) when `stall`, `ex_flush` or !`id_valid`.
- A slot "hits" source s when: valid && we && dest==s && s!=0 && the corresponding use bit is set.
- Load-use stall: the EX slot hits rs or rt and EX.is_load. In that case `stall`=1, which drives:
  - `pc_wr_en`=0
  - `ifid_wr_en`=0
  - `idex_bubble`=1
- Forward select encoding, computed per source in ID and registered so it is valid while the consumer is in EX:
  - 00: ID/EX register-file operand.
  - 01: EX/MEM ALU result. Chosen when the EX slot hits.
  - 10: MEM/WB write-back data. Chosen when the MEM slot hits and the EX slot does not.
  - 11: never driven.
- The EX slot has priority over the MEM slot (youngest producer wins).
- During a stall the registered selects load 00 (the consumer entering EX is a bubble).
- `ex_flush` behaviour:
  - Forces `ifid_flush`=1 and `idex_bubble`=1.
  - Suppresses `stall`, so `pc_wr_en`=1 and `ifid_wr_en`=1.
  - Registered selects load 00.
- `stall_cnt` increments on each cycle with `stall`=1 and saturates at all-ones.

## Timing
- Reset values:
  - All slots invalid; selects 00; `stall_cnt` 0.
  - Because the slots are invalid, `pc_wr_en`=1, `ifid_wr_en`=1, `ifid_flush`=0, `idex_bubble`=0 (and `id_byp_*`=0).
- `stall`, `pc_wr_en`, `ifid_*`, `idex_bubble` and `id_byp_*` are combinational from the slots and the ID inputs, with zero latency.
- `ex_fwd_*_sel` has one-cycle latency (registered at the ID→EX edge).
- A load-use stall lasts exactly 1 cycle. In the next cycle the load sits in MEM, the re-evaluated consumer hits the MEM slot, and it enters EX with select 10.
- `rst` asserted mid-stream clears all state immediately, regardless of the clock.

## Configuration
- `HZ_RF_BYPASS_EN` defined:
  - A WB-slot hit on rs or rt drives `id_byp_a` / `id_byp_b`=1 combinationally.
  - The ID register-file read is muxed to the WB data.
  - No stall is caused.
- `HZ_RF_BYPASS_EN` not defined:
  - The `id_byp_*` ports are absent.
  - A WB-slot hit (with no EX/MEM hit) causes a 1-cycle stall, so the register file is written before it is read.
  - That stall is counted in `stall_cnt`.

## Structure
- Shared package `cpu_pipe_pkg` holds:
  - `FWD_RF`=2'b00, `FWD_EXMEM`=2'b01, `FWD_MEMWB`=2'b10.
  - The `hz_slot_t` struct {valid, dest, we, is_load}.
  - `REG_ZERO`=5'd0.
- One sub-module, `hz_slot_match`: combinational hit detection for one slot against one source, instantiated 6 times (3 slots × 2 sources).

## Test plan
- Back-to-back ALU ops: add $3,$1,$2 then sub $4,$3,$5 → no stall; `ex_fwd_a_sel`=01 during the sub's EX cycle.
- One-gap dependency: add $3 ; nop ; or $6,$3,$3 → `ex_fwd_a_sel`=`ex_fwd_b_sel`=10.
- Load-use: lw $8,0($9) then add $10,$8,$1 → 1 cycle with `pc_wr_en`=0 and `idex_bubble`=1, then `ex_fwd_a_sel`=10; `stall_cnt` goes 0→1.
- Writes to $0: add $0,$1,$2 then add $4,$0,$0 → selects stay 00, no stall.
- Flush during load-use: `ex_flush`=1 in the stall-condition cycle → `stall` suppressed, `ifid_flush`=1, `idex_bubble`=1, selects 00.
- WB hit, 3-apart dependency: bypass build → `id_byp_a`=1, no stall; non-bypass build → 1 stall cycle. Then assert `rst` mid-stream → all outputs return to their reset values asynchronously.
